// File: rtl/voice_pkg.sv
// Shared constants for the voice scheduler: key count, key index width and
// the per-key tone half-period table (in CLOCK_50 cycles).
package voice_pkg;

  localparam int NUM_KEYS = 24;
  localparam int KEY_W    = 5;
  localparam int HALF_W   = 19;

  // Index 0 = C3 ... 23 = B4, chromatic.
  localparam logic [HALF_W-1:0] HALF_PERIOD [NUM_KEYS] = '{
    19'd190080, 19'd180129, 19'd170068, 19'd160458, 19'd151515, 19'd143003,
    19'd135135, 19'd127551, 19'd120481, 19'd113636, 19'd107290, 19'd101214,
    19'd95238,  19'd90177,  19'd85470,  19'd80290,  19'd75758,  19'd71644,
    19'd67567,  19'd63723,  19'd60240,  19'd56818,  19'd53598,  19'd50584
  };

  // Out-of-table keys map to 0 so a stray index can never read past the table.
  function automatic logic [HALF_W-1:0] half_period(input logic [KEY_W-1:0] key);
    if (int'(key) < NUM_KEYS) return HALF_PERIOD[key];
    return '0;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave tone generator: free-running counter that reloads at the
// half period and flips the output phase.
module tone_voice
  import voice_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              load,
  input  logic [HALF_W-1:0] half,
  output logic              phase
);

  logic [HALF_W-1:0] cnt;

  // Load restarts the tone in phase 0; otherwise count while allocated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (load) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (busy) begin
      if (cnt == half) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// Polyphonic key-to-voice scheduler: synchronises keys, scans pending
// press/release events one key per cycle, allocates voices with LRU stealing
// and mixes the square-wave voices into a handshaked sample stream.
module voice_scheduler
  import voice_pkg::*;
#(
  parameter int                 NUM_KEYS   = voice_pkg::NUM_KEYS,
  parameter int                 NUM_VOICES = 4,
  parameter logic signed [31:0] AMP        = 32'sd100000000
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic [NUM_KEYS-1:0]         key_in,
  input  logic                        sample_ready,
  output logic                        sample_valid,
  output logic signed [31:0]          sample_out,
  output logic [NUM_VOICES-1:0]       voice_busy,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic                        steal_pulse
);

  localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int AGE_W = VW;

  logic [NUM_KEYS-1:0] sync1, sync2, sync3, rise, fall;
  logic [NUM_KEYS-1:0] pend_press, pend_release, clr_press, clr_rel;
  logic [1:0]          warm;
  logic [KEY_W-1:0]    ptr;

  logic [NUM_VOICES-1:0]            busy, busy_n, phase, load;
  logic [NUM_VOICES-1:0][KEY_W-1:0] vkey, vkey_n;
  logic [NUM_VOICES-1:0][AGE_W-1:0] age, age_n;

  logic          do_rel, do_press, hit, free_ok, steal;
  logic [VW-1:0] hit_idx, free_idx, old_idx, target;
  logic [AGE_W-1:0] old_age;
  logic signed [31:0] mix;

  assign voice_busy = busy;
  assign voice_key  = vkey;

  // Two-flop synchroniser plus edge register. Edges are ignored until the
  // pipeline has refilled after reset, so keys held through reset do not
  // look like fresh presses.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      warm  <= '0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      sync3 <= sync2;
      if (warm != 2'd3) warm <= warm + 1'b1;
    end
  end

  assign rise = (warm == 2'd3) ? (sync2 & ~sync3) : '0;
  assign fall = (warm == 2'd3) ? (~sync2 & sync3) : '0;

  // Voice search for the scanned key: existing owner, first free, oldest.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    old_idx  = '0;
    old_age  = age[0];
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!hit && busy[v] && vkey[v] == ptr) begin
        hit     = 1'b1;
        hit_idx = VW'(v);
      end
      if (!free_ok && !busy[v]) begin
        free_ok  = 1'b1;
        free_idx = VW'(v);
      end
      if (age[v] > old_age) begin
        old_age = age[v];
        old_idx = VW'(v);
      end
    end
  end

  // Service at most one event for the scanned key; release wins over press.
  always_comb begin
    do_rel    = pend_release[ptr];
    do_press  = ~do_rel & pend_press[ptr];
    clr_rel   = '0;
    clr_press = '0;
    busy_n    = busy;
    vkey_n    = vkey;
    age_n     = age;
    load      = '0;
    steal     = 1'b0;
    target    = hit ? hit_idx : (free_ok ? free_idx : old_idx);
    if (do_rel) begin
      clr_rel[ptr] = 1'b1;
      // A stolen key finds no owner and is dropped silently.
      if (hit) begin
        busy_n[hit_idx] = 1'b0;
        age_n[hit_idx]  = '0;
        for (int v = 0; v < NUM_VOICES; v++)
          if (busy[v] && VW'(v) != hit_idx && age[v] > age[hit_idx])
            age_n[v] = age[v] - 1'b1;
      end
    end else if (do_press) begin
      clr_press[ptr] = 1'b1;
      steal          = ~hit & ~free_ok;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (VW'(v) == target) begin
          busy_n[v] = 1'b1;
          vkey_n[v] = ptr;
          age_n[v]  = '0;
          load[v]   = 1'b1;
        end else if (busy[v] && (!busy[target] || age[v] < age[target])) begin
          age_n[v] = age[v] + 1'b1;
        end
      end
    end
  end

  // Scan pointer, pending-event flags and voice allocation state.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ptr          <= '0;
      pend_press   <= '0;
      pend_release <= '0;
      busy         <= '0;
      vkey         <= '0;
      age          <= '0;
      steal_pulse  <= 1'b0;
    end else begin
      ptr          <= (ptr == KEY_W'(NUM_KEYS - 1)) ? '0 : ptr + 1'b1;
      pend_press   <= (pend_press & ~clr_press) | rise;
      pend_release <= (pend_release & ~clr_rel) | fall;
      busy         <= busy_n;
      vkey         <= vkey_n;
      age          <= age_n;
      steal_pulse  <= steal;
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    tone_voice u_tone (
      .clk   (CLOCK_50),
      .rst   (reset),
      .busy  (busy[v]),
      .load  (load[v]),
      .half  (half_period(vkey[v])),
      .phase (phase[v])
    );
  end

  // Mix busy voices as +/-AMP square waves.
  always_comb begin
    mix = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      if (busy[v]) mix = mix + (phase[v] ? AMP : -AMP);
  end

  // Output register: refill when empty or when the consumer takes a sample.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sample_valid <= 1'b0;
      sample_out   <= '0;
    end else begin
      sample_valid <= 1'b1;
      if (!sample_valid || sample_ready) sample_out <= mix;
    end
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: table-driven scenarios, directed corner cases
// and random key activity, all compared every cycle against an LRU-based
// reference model.
module tb_voice_scheduler;
  localparam int NK = 24;
  localparam int NV = 4;
  localparam logic signed [31:0] AMP = 32'sd100000000;
  localparam int HP [NK] = '{190080,180129,170068,160458,151515,143003,135135,127551,
                             120481,113636,107290,101214,95238,90177,85470,80290,
                             75758,71644,67567,63723,60240,56818,53598,50584};

  logic clk = 1'b0, rst = 1'b1, ready = 1'b1;
  logic [NK-1:0] keys = '0;
  logic sample_valid, steal_pulse;
  logic signed [31:0] sample_out;
  logic [NV-1:0] voice_busy;
  logic [NV*5-1:0] voice_key;

  voice_scheduler dut (
    .CLOCK_50(clk), .reset(rst), .key_in(keys), .sample_ready(ready),
    .sample_valid(sample_valid), .sample_out(sample_out), .voice_busy(voice_busy),
    .voice_key(voice_key), .steal_pulse(steal_pulse)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit [NK-1:0] h1, h2, h3, pp, pr;
  int mptr, cyc, steals;
  bit mbusy [NV];
  int mkey [NV];
  int alloc_at [NV];
  int lru [$];                  // busy voices, most recently allocated first
  bit msteal, mvalid;
  logic signed [31:0] mout;
  int checks = 0, errors = 0;

  typedef struct {
    logic [NK-1:0] keys;
    int            ticks;
    logic [NV-1:0] busy;
    logic [19:0]   vkey;
    int            steals;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    h1 = keys; h2 = keys; h3 = keys;
    pp = '0; pr = '0; mptr = 0; cyc = 0;
    for (int v = 0; v < NV; v++) begin mbusy[v] = 0; mkey[v] = 0; alloc_at[v] = 0; end
    lru.delete();
    msteal = 0; mvalid = 0; mout = 0;
  endtask

  function automatic logic signed [31:0] model_mix();
    logic signed [31:0] s = 0;
    for (int v = 0; v < NV; v++)
      if (mbusy[v]) s += (((cyc - alloc_at[v]) / (HP[mkey[v]] + 1)) % 2 == 1) ? AMP : -AMP;
    return s;
  endfunction

  task automatic lru_remove(input int v);
    for (int i = 0; i < lru.size(); i++)
      if (lru[i] == v) begin lru.delete(i); break; end
  endtask

  task automatic m_press(input int k);
    int t = -1;
    for (int v = 0; v < NV; v++) if (t < 0 && mbusy[v] && mkey[v] == k) t = v;
    if (t < 0) for (int v = 0; v < NV; v++) if (t < 0 && !mbusy[v]) t = v;
    if (t < 0) begin t = lru[lru.size()-1]; msteal = 1; end
    lru_remove(t);
    lru.push_front(t);
    mbusy[t] = 1; mkey[t] = k; alloc_at[t] = cyc;
  endtask

  task automatic m_release(input int k);
    for (int v = 0; v < NV; v++)
      if (mbusy[v] && mkey[v] == k) begin mbusy[v] = 0; lru_remove(v); end
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    logic signed [31:0] mix;
    bit [NK-1:0] rise, fall;
    int k;
    if (rst) begin model_reset(); return; end
    mix  = model_mix();
    rise = h2 & ~h3;
    fall = ~h2 & h3;
    cyc++;
    msteal = 0;
    k = mptr;
    if (pr[k]) begin pr[k] = 0; m_release(k); end
    else if (pp[k]) begin pp[k] = 0; m_press(k); end
    pp |= rise; pr |= fall;
    mptr = (mptr + 1) % NK;
    h3 = h2; h2 = h1; h1 = keys;
    if (!mvalid || ready) mout = mix;
    mvalid = 1;
  endtask

  task automatic tick();
    logic [19:0] ek = '0;
    model_step();
    @(posedge clk);
    #1;
    for (int v = 0; v < NV; v++) ek[v*5 +: 5] = 5'(mkey[v]);
    chk("voice_busy", 32'(voice_busy), 32'({mbusy[3], mbusy[2], mbusy[1], mbusy[0]}));
    chk("voice_key", 32'(voice_key), 32'(ek));
    chk("steal_pulse", 32'(steal_pulse), 32'(msteal));
    chk("sample_valid", 32'(sample_valid), 32'(mvalid));
    chk("sample_out", sample_out, mout);
    if (steal_pulse) steals++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before the next edge.
  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(voice_busy), 0);
    chk("async_rst_key", 32'(voice_key), 0);
    chk("async_rst_valid", 32'(sample_valid), 0);
    chk("async_rst_out", sample_out, 0);
    chk("async_rst_steal", 32'(steal_pulse), 0);
    model_reset();
    ticks(3);
    rst = 1'b0;
  endtask

  task automatic wait_voice(input int v, input int k, input int lim, input string nm);
    int n = 0;
    while (n < lim && !(voice_busy[v] && voice_key[v*5 +: 5] == 5'(k))) begin tick(); n++; end
    checks++;
    if (!(voice_busy[v] && voice_key[v*5 +: 5] == 5'(k))) begin
      errors++;
      $display("FAIL %s: voice %0d not holding key %0d after %0d cycles", nm, v, k, lim);
    end
  endtask

  initial begin
    tbl[0] = '{keys: 24'h000000, ticks: 21, busy: 4'b0000, vkey: 20'h0, steals: 0};
    tbl[1] = '{keys: 24'h001091, ticks: 40, busy: 4'b1111,
               vkey: {5'd12, 5'd7, 5'd4, 5'd0}, steals: 0};
    tbl[2] = '{keys: 24'h011091, ticks: 40, busy: 4'b1111,
               vkey: {5'd12, 5'd7, 5'd4, 5'd16}, steals: 1};
    tbl[3] = '{keys: 24'h011090, ticks: 40, busy: 4'b1111,
               vkey: {5'd12, 5'd7, 5'd4, 5'd16}, steals: 0};
    tbl[4] = '{keys: 24'h000000, ticks: 40, busy: 4'b0000,
               vkey: {5'd12, 5'd7, 5'd4, 5'd16}, steals: 0};

    model_reset();
    ticks(2);
    chk("reset_valid", 32'(sample_valid), 0);
    chk("reset_busy", 32'(voice_busy), 0);
    rst = 1'b0;

    // Chord allocation in scan order, steal, stolen-key release, full release.
    for (int i = 0; i < 5; i++) begin
      keys = tbl[i].keys;
      steals = 0;
      ticks(tbl[i].ticks);
      chk($sformatf("tbl%0d_busy", i), 32'(voice_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_key", i), 32'(voice_key), 32'(tbl[i].vkey));
      chk($sformatf("tbl%0d_steals", i), steals, tbl[i].steals);
    end

    // Press and release key 5 before its visit: release first, press next lap.
    for (int n = 0; n < 30 && mptr != 6; n++) tick();
    keys[5] = 1'b1; ticks(2);
    keys[5] = 1'b0; ticks(60);
    chk("pr_busy", 32'(voice_busy), 32'h1);
    chk("pr_key0", 32'(voice_key[4:0]), 5);
    keys[5] = 1'b1; ticks(40);
    chk("pr_restart_busy", 32'(voice_busy), 32'h1);
    keys[5] = 1'b0; ticks(40);
    chk("pr_freed", 32'(voice_busy), 0);

    // Back-pressure: sample held while mix changes, updates on transfer.
    ready = 1'b0;
    tick();
    chk("bp_start", sample_out, 0);
    keys[9] = 1'b1; keys[10] = 1'b1;
    ticks(500);
    chk("bp_busy", 32'(voice_busy), 32'h3);
    chk("bp_held", sample_out, 0);
    ready = 1'b1;
    tick();
    chk("bp_transfer", sample_out, -2 * AMP);
    keys = '0; ticks(40);

    // Reset with three voices busy and keys still held.
    keys = 24'h00000E; ticks(60);
    chk("rst_pre_busy", 32'(voice_busy), 32'h7);
    do_reset();
    ticks(60);
    chk("rst_held_no_alloc", 32'(voice_busy), 0);
    keys = '0; ticks(10);
    keys[2] = 1'b1; ticks(40);
    chk("rst_repress_busy", 32'(voice_busy), 32'h1);
    chk("rst_repress_key", 32'(voice_key[4:0]), 2);
    keys = '0; ticks(40);

    // Single key latency and tone phase toggling.
    keys[9] = 1'b1;
    wait_voice(0, 9, 27, "a3_latency");
    ticks(2);
    chk("a3_low_phase", sample_out, -AMP);
    keys[23] = 1'b1;
    wait_voice(1, 23, 27, "b4_latency");
    ticks(2);
    chk("two_low", sample_out, -2 * AMP);
    ticks(50590);
    chk("b4_toggled", sample_out, 0);
    keys = '0; ticks(40);

    // Random key activity with random back-pressure and one mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        ticks(6);
      end
      if ($urandom_range(0, 5) == 0) keys[$urandom_range(0, NK-1)] ^= 1'b1;
      ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 Parameter NUM_KEYS, default 24, number of key inputs; index 0 = C3 ... 23 = B4, chromatic.
REQ-002 Parameter NUM_VOICES, default 4, number of square-wave tone voices.
REQ-003 Parameter AMP, default 32'd100000000, per-voice signed amplitude.
REQ-004 CLOCK_50  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 key_in  in  NUM_KEYS  raw key levels, 1 = pressed; asynchronous to CLOCK_50.
REQ-007 sample_ready  in  1  consumer can accept a sample (driven from audio_out_allowed).
REQ-008 sample_valid  out  1  sample_out holds a valid sample.
REQ-009 sample_out  out  32  signed mixed sample.
REQ-010 voice_busy  out  NUM_VOICES  bit v = voice v allocated.
REQ-011 voice_key  out  NUM_VOICES*5  5-bit key index per voice, voice v at bits [5v+4:5v].
REQ-012 steal_pulse  out  1  one-cycle pulse when an allocation evicts a busy voice.

Function
REQ-013 key_in SHALL pass a 2-flop synchronizer, then a third register for edge detection; rise sets pend_press[k], fall sets pend_release[k].
REQ-014 A 5-bit scan pointer SHALL step 0..NUM_KEYS-1 and wrap to 0, advancing one key per cycle; at most one event is serviced per cycle, for the pointed key only.
REQ-015 If both pend_release[k] and pend_press[k] are set, the release SHALL be serviced first and the press on the next visit; each bit clears when serviced.
REQ-016 Release: free the voice whose key equals k; if none (key was stolen), discard with no other effect.
REQ-017 Press: if k already occupies a voice, restart that voice; else take the lowest-index free voice; else steal the voice with the largest age (ties to lowest index) and pulse steal_pulse.
REQ-018 Age: each voice holds a 2-bit ordinal (log2 NUM_VOICES). On allocation the target gets age 0; busy voices younger than the target's old age (or all busy voices when the target was free) increment. Busy ages stay a permutation of 0..busy_count-1.
REQ-019 Allocation sets voice_busy, voice_key, tone counter = 0, phase = 0, all on the same edge; outputs visible the next cycle.
REQ-020 Per voice, a 19-bit counter SHALL run continuously while busy; when it equals HALF_PERIOD[voice_key] it reloads 0 and phase toggles.
REQ-021 Mix = sum over busy voices of (phase ? +AMP : -AMP); idle voices contribute 0; 32-bit two's complement, no saturation (NUM_VOICES*AMP < 2^31).
REQ-022 Handshake: sample_out loads the current mix when sample_valid = 0 or (sample_valid & sample_ready); otherwise holds. Transfer occurs on cycles with sample_valid & sample_ready.
REQ-023 sample_valid SHALL rise on the first edge after reset deasserts and stay 1; sample_out may change only on a transfer cycle.
REQ-024 Worst-case press-to-voice latency SHALL be NUM_KEYS + 3 cycles (sync + edge + full scan).

Reset
REQ-025 Reset SHALL clear synchronizer/edge registers, pend_press, pend_release, scan pointer, voice_busy, voice_key, ages, tone counters, phases, steal_pulse, sample_valid and sample_out to 0.
REQ-026 Reset mid-operation SHALL drop all pending events and voices immediately; after release, keys already held produce no press event until released and pressed again.

Structure
REQ-027 Shared package voice_pkg SHALL hold NUM_KEYS, key-index width, and the HALF_PERIOD table: 190080,180129,170068,160458,151515,143003,135135,127551,120481,113636,107290,101214, 95238,90177,85470,80290,75758,71644,67567,63723,60240,56818,53598,50584.
REQ-028 One sub-module tone_voice (counter, phase, half-period compare) SHALL be instantiated NUM_VOICES times; allocation and mixing stay in voice_scheduler.

Verification
REQ-029 Press key 9 (A3) alone -> voice 0 busy, voice_key0 = 9 within 27 cycles; phase toggles every 113637 cycles; sample_out alternates +/-100000000.
REQ-030 Press keys 0,4,7,12 together -> voices 0..3 get keys 0,4,7,12 in scan order; press key 16 -> steal_pulse once, voice 0 now key 16.
REQ-031 Press key 5 then release before service -> both pend bits set; release serviced first (no-op), press next visit; voice allocated; release again -> voice freed.
REQ-032 Hold sample_ready = 0 for 500 cycles with 2 voices toggling -> sample_out constant; raise ready -> new value on the next transfer edge.
REQ-033 Assert reset with 3 voices busy and keys held -> all outputs 0 asynchronously; after release, no voices allocate until a key is re-pressed.
REQ-034 Release a stolen key -> no voice changes, no steal_pulse.
